jpeg_block_sequencer: RTL and testbench

Control sequencer for the per-component JPEG encoder pipeline. It takes 8x8 blocks of pixels from a valid/ready pixel source and generates the stage strobes shared by the Y, Cb and Cr encoder instances: pixel load, DCT rows, DCT end, zigzag load/scan and Huffman start. It replaces the testbench-driven control pins on the encoder top. It counts blocks over a frame, waits for Huffman completion per block, and flags Huffman stalls.

---
 rtl/jpeg_seq_pkg.sv | 21 ++
 rtl/jpeg_block_sequencer_pix_en_delay.sv | 30 +++
 rtl/jpeg_block_sequencer.sv | 148 ++++++++++++++
 tb/tb_jpeg_block_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_seq_pkg.sv
// Shared types and constants for the JPEG block sequencer.
// Holds the sequencer state encoding and the block geometry constants.
package jpeg_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        DRAIN,
        DCT,
        DCT_END,
        ZZ_IN,
        ZZ,
        HUFF_START,
        HUFF_WAIT,
        NEXT
    } seq_state_t;

    localparam int PIX_PER_BLOCK = 64;
    localparam int BLK_IDX_W     = 16;

endpackage

// File: rtl/jpeg_block_sequencer_pix_en_delay.sv
// Single-bit delay line that keeps the pixel write strobe aligned with colour-converted data.
// Latency DEPTH cycles (DEPTH=0 is a combinational pass-through); no backpressure.
module pix_en_delay #(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0] sr;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sr <= '0;
                end else begin
                    sr <= (sr << 1) | DEPTH'(din);
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Block-level control sequencer for the Y/Cb/Cr encoder pipeline: load, DCT, zigzag, Huffman.
// Strobes are registered and aligned to the state they belong to; pix_ready is decoded from state.
module jpeg_block_sequencer
    import jpeg_seq_pkg::*;
#(
    parameter int CSC_LATENCY  = 1,
    parameter int DCT_ROWS     = 8,
    parameter int ZZ_CYCLES    = 8,
    parameter int HUFF_TIMEOUT = 1023
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [BLK_IDX_W-1:0] num_blocks,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 huff_done,
    output logic                 input_1pix_enable,
    output logic                 dct_enable,
    output logic [7:0]           matrix_row,
    output logic                 dct_end_enable,
    output logic                 zigzag_input_enable,
    output logic                 zigag_enable,
    output logic                 Huffman_start,
    output logic                 busy,
    output logic [BLK_IDX_W-1:0] block_index,
    output logic                 block_done,
    output logic                 frame_done,
    output logic                 huff_err
);

    localparam logic [15:0] DRAIN_LAST = 16'(CSC_LATENCY - 1);
    localparam logic [15:0] DCT_LAST   = 16'(DCT_ROWS - 1);
    localparam logic [15:0] ZZ_LAST    = 16'(ZZ_CYCLES - 1);
    localparam logic [15:0] HUFF_LAST  = 16'(HUFF_TIMEOUT - 1);
    localparam logic [5:0]  PIX_LAST   = 6'(PIX_PER_BLOCK - 1);

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [5:0]           pix_cnt;
    logic [15:0]          phase_cnt;
    logic [15:0]          phase_nxt;
    logic [BLK_IDX_W-1:0] num_blocks_q;
    logic                 accept;
    logic                 huff_timeout;
    logic                 last_block;

    assign pix_ready  = (state == LOAD);
    assign accept     = pix_valid & pix_ready;
    assign last_block = (block_index == (num_blocks_q - 16'd1));

    pix_en_delay #(
        .DEPTH (CSC_LATENCY)
    ) u_pix_en_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (accept),
        .dout    (input_1pix_enable)
    );

    // phase_cnt counts cycles spent in the current state; it restarts on every state change.
    always_comb begin
        state_nxt    = state;
        huff_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_blocks == '0) ? NEXT : LOAD;
                end
            end
            LOAD: begin
                if (accept && (pix_cnt == PIX_LAST)) begin
                    state_nxt = (CSC_LATENCY == 0) ? DCT : DRAIN;
                end
            end
            DRAIN: begin
                if (phase_cnt == DRAIN_LAST) state_nxt = DCT;
            end
            DCT: begin
                if (phase_cnt == DCT_LAST) state_nxt = DCT_END;
            end
            DCT_END:    state_nxt = ZZ_IN;
            ZZ_IN:      state_nxt = ZZ;
            ZZ: begin
                if (phase_cnt == ZZ_LAST) state_nxt = HUFF_START;
            end
            HUFF_START: state_nxt = HUFF_WAIT;
            HUFF_WAIT: begin
                if (huff_done) begin
                    state_nxt = NEXT;
                end else if (phase_cnt == HUFF_LAST) begin
                    state_nxt    = NEXT;
                    huff_timeout = 1'b1;
                end
            end
            // frame_done is already high in NEXT when this was the final block
            NEXT:       state_nxt = frame_done ? IDLE : LOAD;
            default:    state_nxt = IDLE;
        endcase
        phase_nxt = (state_nxt == state) ? (phase_cnt + 16'd1) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            phase_cnt           <= '0;
            pix_cnt             <= '0;
            num_blocks_q        <= '0;
            block_index         <= '0;
            huff_err            <= 1'b0;
            dct_enable          <= 1'b0;
            matrix_row          <= '0;
            dct_end_enable      <= 1'b0;
            zigzag_input_enable <= 1'b0;
            zigag_enable        <= 1'b0;
            Huffman_start       <= 1'b0;
            busy                <= 1'b0;
            block_done          <= 1'b0;
            frame_done          <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;

            if ((state == IDLE) && start) begin
                num_blocks_q <= num_blocks;
                block_index  <= '0;
                huff_err     <= 1'b0;
                pix_cnt      <= '0;
            end else begin
                if (accept) pix_cnt <= pix_cnt + 6'd1;
                if (huff_timeout) huff_err <= 1'b1;
                if ((state == NEXT) && block_done) block_index <= block_index + 16'd1;
            end

            dct_enable          <= (state_nxt == DCT);
            matrix_row          <= (state_nxt == DCT) ? phase_nxt[7:0] : 8'd0;
            dct_end_enable      <= (state_nxt == DCT_END);
            zigzag_input_enable <= (state_nxt == ZZ_IN);
            zigag_enable        <= (state_nxt == ZZ);
            Huffman_start       <= (state_nxt == HUFF_START);
            busy                <= (state_nxt != IDLE);
            block_done          <= (state == HUFF_WAIT) && (state_nxt == NEXT);
            // An empty frame goes IDLE -> NEXT and reports frame_done alone.
            frame_done          <= (state_nxt == NEXT) && ((state == IDLE) || last_block);
        end
    end

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Self-checking bench: per-frame expected cycle traces built from the block timing rules.
module tb_jpeg_block_sequencer;

    localparam int CSC  = 1;
    localparam int ROWS = 8;
    localparam int ZZN  = 8;
    localparam int TO   = 16;
    localparam int MAXC = 4096;

    localparam int K_IPE = 0;
    localparam int K_DCT = 1;
    localparam int K_HS  = 2;
    localparam int K_BD  = 3;
    localparam int K_FD  = 4;

    typedef struct packed {
        logic        pr;
        logic        ipe;
        logic        dct;
        logic [7:0]  row;
        logic        de;
        logic        zi;
        logic        zz;
        logic        hs;
        logic        busy;
        logic        bd;
        logic        fd;
        logic        herr;
        logic [15:0] bidx;
    } out_t;

    typedef struct packed {
        logic        start;
        logic [15:0] nb;
        logic        pv;
        logic        hd;
        out_t        o;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_blocks = '0;
    logic        pix_valid = 1'b0;
    logic        huff_done = 1'b0;
    logic        pix_ready, input_1pix_enable, dct_enable, dct_end_enable;
    logic        zigzag_input_enable, zigag_enable, Huffman_start, busy;
    logic        block_done, frame_done, huff_err;
    logic [7:0]  matrix_row;
    logic [15:0] block_index;

    jpeg_block_sequencer #(
        .CSC_LATENCY  (CSC),
        .DCT_ROWS     (ROWS),
        .ZZ_CYCLES    (ZZN),
        .HUFF_TIMEOUT (TO)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start               (start),
        .num_blocks          (num_blocks),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready),
        .huff_done           (huff_done),
        .input_1pix_enable   (input_1pix_enable),
        .dct_enable          (dct_enable),
        .matrix_row          (matrix_row),
        .dct_end_enable      (dct_end_enable),
        .zigzag_input_enable (zigzag_input_enable),
        .zigag_enable        (zigag_enable),
        .Huffman_start       (Huffman_start),
        .busy                (busy),
        .block_index         (block_index),
        .block_done          (block_done),
        .frame_done          (frame_done),
        .huff_err            (huff_err)
    );

    always #5 clock = ~clock;

    ent_t tr  [0:MAXC-1];
    bit   acc [0:MAXC-1];
    int   tlen;
    int   hdly [0:3];
    logic m_herr = 1'b0;
    logic [15:0] m_bidx = '0;

    out_t cur;
    out_t act;
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    // Single compare process: every checked cycle, DUT outputs against the expected trace entry.
    always @(negedge clock) begin
        if (chk_en) begin
            act.pr   = pix_ready;
            act.ipe  = input_1pix_enable;
            act.dct  = dct_enable;
            act.row  = matrix_row;
            act.de   = dct_end_enable;
            act.zi   = zigzag_input_enable;
            act.zz   = zigag_enable;
            act.hs   = Huffman_start;
            act.busy = busy;
            act.bd   = block_done;
            act.fd   = frame_done;
            act.herr = huff_err;
            act.bidx = block_index;
            tests++;
            if (act !== cur) begin
                fails++;
                $display("FAIL outputs cycle %0d: got pr=%b ipe=%b dct=%b row=%0d de=%b zi=%b zz=%b hs=%b busy=%b bd=%b fd=%b err=%b bidx=%0d ; want pr=%b ipe=%b dct=%b row=%0d de=%b zi=%b zz=%b hs=%b busy=%b bd=%b fd=%b err=%b bidx=%0d",
                         cyc, act.pr, act.ipe, act.dct, act.row, act.de, act.zi, act.zz, act.hs,
                         act.busy, act.bd, act.fd, act.herr, act.bidx,
                         cur.pr, cur.ipe, cur.dct, cur.row, cur.de, cur.zi, cur.zz, cur.hs,
                         cur.busy, cur.bd, cur.fd, cur.herr, cur.bidx);
            end
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // A busy-looking cycle with random don't-care inputs (including ignored start pulses).
    function automatic ent_t base();
        ent_t e;
        e        = '0;
        e.pv     = 1'($urandom_range(0, 1));
        e.hd     = 1'($urandom_range(0, 1));
        e.start  = ($urandom_range(0, 15) == 0);
        e.nb     = 16'($urandom);
        e.o.busy = 1'b1;
        e.o.herr = m_herr;
        e.o.bidx = m_bidx;
        return e;
    endfunction

    task automatic push(input ent_t e);
        tr[tlen] = e;
        tlen++;
    endtask

    // pv_mode: 0 = always valid, 1 = toggling from 1, 2 = random 75% valid
    task automatic build_frame(input int n, input int pv_mode);
        ent_t e;
        int   cnt, k, d, w_len;
        tlen = 0;
        for (int i = 0; i < MAXC; i++) acc[i] = 1'b0;
        e = base();
        e.start = 1'b1;
        e.nb = 16'(n);
        e.o.busy = 1'b0;
        push(e);
        m_herr = 1'b0;
        m_bidx = '0;
        if (n == 0) begin
            e = base();
            e.o.fd = 1'b1;
            push(e);
        end
        for (int b = 0; b < n; b++) begin
            cnt = 0;
            k = 0;
            while (cnt < 64) begin
                e = base();
                e.o.pr = 1'b1;
                if (pv_mode == 0)      e.pv = 1'b1;
                else if (pv_mode == 1) e.pv = (k % 2 == 0);
                else                   e.pv = ($urandom_range(0, 3) != 0);
                if (e.pv) begin
                    acc[tlen] = 1'b1;
                    cnt++;
                end
                push(e);
                k++;
            end
            for (int i = 0; i < CSC; i++) push(base());
            for (int r = 0; r < ROWS; r++) begin
                e = base();
                e.o.dct = 1'b1;
                e.o.row = 8'(r);
                push(e);
            end
            e = base(); e.o.de = 1'b1; push(e);
            e = base(); e.o.zi = 1'b1; push(e);
            for (int z = 0; z < ZZN; z++) begin
                e = base(); e.o.zz = 1'b1; push(e);
            end
            e = base(); e.o.hs = 1'b1; push(e);
            d = hdly[b];
            w_len = (d <= TO) ? d : TO;
            for (int w = 1; w <= w_len; w++) begin
                e = base();
                e.hd = (d <= TO) && (w == w_len);
                push(e);
            end
            if (d > TO) m_herr = 1'b1;
            e = base();
            e.o.herr = m_herr;
            e.o.bd = 1'b1;
            e.o.fd = (b == n - 1);
            push(e);
            m_bidx = m_bidx + 16'd1;
        end
        for (int i = 0; i < 3; i++) begin
            e = base();
            e.start = 1'b0;
            e.o.busy = 1'b0;
            push(e);
        end
        for (int i = 0; i < tlen; i++) begin
            if (acc[i]) tr[i + CSC].o.ipe = 1'b1;
        end
    endtask

    function automatic bit has(input ent_t e, input int kind);
        case (kind)
            K_IPE:   return e.o.ipe;
            K_DCT:   return e.o.dct;
            K_HS:    return e.o.hs;
            K_BD:    return e.o.bd;
            default: return e.o.fd;
        endcase
    endfunction

    function automatic int first_of(input int kind);
        for (int i = 0; i < tlen; i++) if (has(tr[i], kind)) return i;
        return -1;
    endfunction

    function automatic int last_of(input int kind);
        int r = -1;
        for (int i = 0; i < tlen; i++) if (has(tr[i], kind)) r = i;
        return r;
    endfunction

    function automatic int cnt_of(input int kind);
        int c = 0;
        for (int i = 0; i < tlen; i++) if (has(tr[i], kind)) c++;
        return c;
    endfunction

    function automatic int row3_idx();
        for (int i = 0; i < tlen; i++) if (tr[i].o.dct && tr[i].o.row == 8'd3) return i;
        return -1;
    endfunction

    // Drives trace entries 0..stop-1 (all entries when stop < 0).
    task automatic run_trace(input int stop);
        int lim;
        lim = (stop < 0) ? tlen : stop;
        for (int i = 0; i < lim; i++) begin
            @(posedge clock); #1;
            start      = tr[i].start;
            num_blocks = tr[i].nb;
            pix_valid  = tr[i].pv;
            huff_done  = tr[i].hd;
            cur        = tr[i].o;
            chk_en     = 1'b1;
            cyc++;
        end
    endtask

    // k cycles in reset, then one released cycle; every output must read 0 throughout.
    task automatic do_reset(input int k);
        for (int i = 0; i <= k; i++) begin
            @(posedge clock); #1;
            reset_n    = (i == k);
            start      = 1'b0;
            pix_valid  = 1'($urandom_range(0, 1));
            huff_done  = 1'($urandom_range(0, 1));
            num_blocks = 16'($urandom);
            cur        = '0;
            chk_en     = 1'b1;
            cyc++;
        end
        m_herr = 1'b0;
        m_bidx = '0;
    endtask

    initial begin
        int n, mode;
        do_reset(3);

        // Single block, full-rate pixels, huff_done on the 5th wait cycle.
        hdly[0] = 5; hdly[1] = 0; hdly[2] = 0; hdly[3] = 0;
        build_frame(1, 0);
        check_int("single_trace_len", tlen, 94);
        check_int("single_ipe_count", cnt_of(K_IPE), 64);
        check_int("single_last_ipe", last_of(K_IPE), 65);
        check_int("single_first_dct", first_of(K_DCT), 66);
        check_int("single_huff_start", first_of(K_HS), 84);
        check_int("single_block_done", first_of(K_BD), 90);
        check_int("single_frame_done", first_of(K_FD), 90);
        run_trace(-1);

        // Three blocks, toggling pix_valid, timeout on the middle block.
        hdly[0] = 3; hdly[1] = 17; hdly[2] = 2;
        build_frame(3, 1);
        check_int("multi_block_done_count", cnt_of(K_BD), 3);
        check_int("multi_frame_done_count", cnt_of(K_FD), 1);
        check_int("multi_ipe_count", cnt_of(K_IPE), 192);
        check_int("multi_err_sticky", int'(tr[tlen-1].o.herr), 1);
        run_trace(-1);

        // Empty frame: clears huff_err, frame_done alone one cycle after the start cycle.
        build_frame(0, 2);
        check_int("empty_frame_done_idx", first_of(K_FD), 1);
        check_int("empty_block_done_count", cnt_of(K_BD), 0);
        check_int("empty_dct_count", cnt_of(K_DCT), 0);
        run_trace(-1);

        // Reset during DCT row 3, then a clean frame.
        hdly[0] = 4; hdly[1] = 4;
        build_frame(2, 2);
        check_int("abort_row3_found", int'(row3_idx() > 0), 1);
        run_trace(row3_idx());
        do_reset(2);
        hdly[0] = 2;
        build_frame(1, 2);
        run_trace(-1);

        for (int f = 0; f < 10; f++) begin
            n    = $urandom_range(0, 4);
            mode = $urandom_range(0, 2);
            for (int b = 0; b < 4; b++) hdly[b] = $urandom_range(1, 20);
            build_frame(n, mode);
            run_trace(-1);
        end

        @(posedge clock); #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
